// File: rtl/spi_reg_bridge.sv
// SPI-slave register bridge: decodes a CMD/ADDR header, then runs burst writes or burst
// reads with address auto-increment for as long as cs stays low.
module spi_reg_bridge #(
  parameter int               CMD_W     = 8,
  parameter int               ADDR_W    = 24,
  parameter int               DATA_W    = 32,
  parameter logic [CMD_W-1:0] WRITE_CMD = 8'h77,
  parameter logic [CMD_W-1:0] READ_CMD  = 8'h72,
  parameter int               ADDR_INC  = 1
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_address_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_address_out,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              cmd_err_out
);

  localparam int MAX_W = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                          : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam int CNT_W = $clog2(MAX_W);
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(DATA_W - 2);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(ADDR_INC);

  // S_CMD/S_ADDR header | S_WDATA write words | S_RTURN fetch word, drive MSB
  // S_RDATA shift remaining read bits | S_IGNORE bad command, wait for cs high
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_RTURN, S_RDATA, S_IGNORE} state_t;

  state_t            state, state_d;
  logic              mode_rd, mode_rd_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [MAX_W-2:0]  rx_shift, rx_shift_d;
  logic [DATA_W-1:0] tx_shift, tx_shift_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              miso_d, wr_en_d, rd_en_d, cmd_err_d;
  logic [ADDR_W-1:0] wr_address_d, rd_address_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [CMD_W-1:0]  cmd_word;
  logic [ADDR_W-1:0] addr_word;
  logic [DATA_W-1:0] data_word;

  // rx_shift keeps only width-1 bits: the current mosi completes each field
  assign cmd_word  = {rx_shift[CMD_W-2:0], mosi};
  assign addr_word = {rx_shift[ADDR_W-2:0], mosi};
  assign data_word = {rx_shift[DATA_W-2:0], mosi};

  always_comb begin
    state_d      = state;
    mode_rd_d    = mode_rd;
    cnt_d        = cnt + CNT_W'(1);
    rx_shift_d   = {rx_shift[MAX_W-3:0], mosi};
    tx_shift_d   = tx_shift;
    addr_d       = addr;
    miso_d       = 1'b0;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_out;
    wr_data_d    = wr_data_out;
    rd_en_d      = 1'b0;
    rd_address_d = rd_address_out;
    cmd_err_d    = 1'b0;
    case (state)
      S_CMD: begin
        if (cnt == CMD_LAST) begin
          cnt_d = '0;
          if (cmd_word == WRITE_CMD) begin
            state_d   = S_ADDR;
            mode_rd_d = 1'b0;
          end else if (cmd_word == READ_CMD) begin
            state_d   = S_ADDR;
            mode_rd_d = 1'b1;
          end else begin
            state_d   = S_IGNORE;
            cmd_err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (cnt == ADDR_LAST) begin
          cnt_d  = '0;
          addr_d = addr_word;
          if (mode_rd) begin
            state_d      = S_RTURN;
            rd_en_d      = 1'b1;
            rd_address_d = addr_word;
          end else begin
            state_d = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (cnt == DATA_LAST) begin
          cnt_d        = '0;
          wr_en_d      = 1'b1;
          wr_address_d = addr;
          wr_data_d    = data_word;
          addr_d       = addr + ADDR_STEP;
        end
      end
      S_RTURN: begin
        cnt_d      = '0;
        tx_shift_d = rd_data_in << 1;
        miso_d     = rd_data_in[DATA_W-1];
        addr_d     = addr + ADDR_STEP;
        state_d    = S_RDATA;
      end
      S_RDATA: begin
        miso_d     = tx_shift[DATA_W-1];
        tx_shift_d = tx_shift << 1;
        if (cnt == RD_LAST) begin
          cnt_d        = '0;
          rd_en_d      = 1'b1;
          rd_address_d = addr;
          state_d      = S_RTURN;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst || cs) begin
      state          <= S_CMD;
      mode_rd        <= 1'b0;
      cnt            <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      addr           <= '0;
      miso           <= 1'b0;
      wr_en_out      <= 1'b0;
      wr_address_out <= '0;
      wr_data_out    <= '0;
      rd_en_out      <= 1'b0;
      rd_address_out <= '0;
      cmd_err_out    <= 1'b0;
    end else begin
      state          <= state_d;
      mode_rd        <= mode_rd_d;
      cnt            <= cnt_d;
      rx_shift       <= rx_shift_d;
      tx_shift       <= tx_shift_d;
      addr           <= addr_d;
      miso           <= miso_d;
      wr_en_out      <= wr_en_d;
      wr_address_out <= wr_address_d;
      wr_data_out    <= wr_data_d;
      rd_en_out      <= rd_en_d;
      rd_address_out <= rd_address_d;
      cmd_err_out    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed vector table plus random frames, checked edge by edge
// against a frame-position model of the bridge.
module tb_spi_reg_bridge;
  logic        sck = 1'b0;
  logic        rst, cs, mosi, miso;
  logic        wr_en_out, rd_en_out, cmd_err_out;
  logic [23:0] wr_address_out, rd_address_out;
  logic [31:0] wr_data_out, rd_data_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wdata[8];
  logic [31:0] rdata[8];
  logic [23:0] m_wr_addr, m_rd_addr;
  logic [31:0] m_wr_data;
  int wr_cnt, rd_cnt, err_cnt;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [31:0] d0;
    logic [31:0] d1;
    int          nedges;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [23:0] exp_addr;
    bit          rd_side;
  } vec_t;
  vec_t tbl[6];

  spi_reg_bridge dut (
    .sck(sck), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso),
    .wr_en_out(wr_en_out), .wr_address_out(wr_address_out), .wr_data_out(wr_data_out),
    .rd_en_out(rd_en_out), .rd_address_out(rd_address_out), .rd_data_in(rd_data_in),
    .cmd_err_out(cmd_err_out)
  );

  always #5 sck = ~sck;

  task automatic check(input string name, input int edge_n, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_all(input int edge_n, input logic e_wr, input logic e_rd,
                           input logic e_miso, input logic e_err);
    check("wr_en", edge_n, 32'(wr_en_out), 32'(e_wr));
    check("wr_addr", edge_n, 32'(wr_address_out), 32'(m_wr_addr));
    check("wr_data", edge_n, wr_data_out, m_wr_data);
    check("rd_en", edge_n, 32'(rd_en_out), 32'(e_rd));
    check("rd_addr", edge_n, 32'(rd_address_out), 32'(m_rd_addr));
    check("miso", edge_n, 32'(miso), 32'(e_miso));
    check("cmd_err", edge_n, 32'(cmd_err_out), 32'(e_err));
  endtask

  task automatic idle_edge(input logic cs_v, input logic rst_v);
    cs = cs_v;
    rst = rst_v;
    mosi = 1'($urandom);
    rd_data_in = $urandom;
    @(posedge sck);
    #1;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_rd_addr = '0;
    check_all(0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Expected outputs follow from the bit position n within the frame:
  // header is 32 bits, each data word 32 bits, read words appear on miso from bit 33.
  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] a, input int nedges);
    bit isw, isr;
    logic b, e_wr, e_rd, e_miso, e_err;
    int k;
    isw = (cmd == 8'h77);
    isr = (cmd == 8'h72);
    wr_cnt = 0;
    rd_cnt = 0;
    err_cnt = 0;
    for (int n = 1; n <= nedges; n++) begin
      if (n <= 8) b = cmd[8-n];
      else if (n <= 32) b = a[32-n];
      else if (isw) b = wdata[(n-33)/32][31-((n-33)%32)];
      else b = 1'($urandom);
      if (isr && n >= 33 && (n-33) % 32 == 0) rd_data_in = rdata[(n-33)/32];
      else rd_data_in = $urandom;
      cs = 1'b0;
      rst = 1'b0;
      mosi = b;
      @(posedge sck);
      #1;
      e_wr = isw && n >= 64 && n % 32 == 0;
      e_rd = isr && n >= 32 && n % 32 == 0;
      e_err = !isw && !isr && n == 8;
      e_miso = 1'b0;
      if (isr && n >= 33) begin
        k = (n-33)/32;
        e_miso = rdata[k][31-((n-33)%32)];
      end
      if (e_wr) begin
        k = n/32 - 2;
        m_wr_addr = a + 24'(k);
        m_wr_data = wdata[k];
      end
      if (e_rd) m_rd_addr = a + 24'(n/32 - 1);
      check_all(n, e_wr, e_rd, e_miso, e_err);
      if (wr_en_out) wr_cnt++;
      if (rd_en_out) rd_cnt++;
      if (cmd_err_out) err_cnt++;
    end
  endtask

  initial begin
    tbl[0] = '{8'h77, 24'h000010, 32'hDEADBEEF, 32'h0, 64, 1, 0, 0, 24'h000010, 1'b0};
    tbl[1] = '{8'h77, 24'hFFFFFF, 32'h11111111, 32'h22222222, 96, 2, 0, 0, 24'h000000, 1'b0};
    tbl[2] = '{8'h72, 24'h000100, 32'hA5A50F0F, 32'h80000000, 65, 0, 2, 0, 24'h000101, 1'b1};
    tbl[3] = '{8'h55, 24'h123456, 32'h0, 32'h0, 108, 0, 0, 1, 24'h000000, 1'b0};
    tbl[4] = '{8'h77, 24'h000020, 32'hCAFEF00D, 32'h0, 52, 0, 0, 0, 24'h000000, 1'b0};
    tbl[5] = '{8'h77, 24'h000020, 32'hCAFEF00D, 32'h0, 64, 1, 0, 0, 24'h000020, 1'b0};

    rst = 1'b1;
    cs = 1'b1;
    mosi = 1'b0;
    rd_data_in = '0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_rd_addr = '0;
    @(posedge sck);
    #1;
    check_all(0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_edge(1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      wdata[0] = tbl[i].d0;
      wdata[1] = tbl[i].d1;
      rdata[0] = tbl[i].d0;
      rdata[1] = tbl[i].d1;
      run_frame(tbl[i].cmd, tbl[i].addr, tbl[i].nedges);
      check("vec_wr_strobes", i, 32'(wr_cnt), 32'(tbl[i].exp_wr));
      check("vec_rd_strobes", i, 32'(rd_cnt), 32'(tbl[i].exp_rd));
      check("vec_cmd_err", i, 32'(err_cnt), 32'(tbl[i].exp_err));
      if (tbl[i].rd_side) check("vec_rd_addr", i, 32'(rd_address_out), 32'(tbl[i].exp_addr));
      else check("vec_wr_addr", i, 32'(wr_address_out), 32'(tbl[i].exp_addr));
      idle_edge(1'b1, 1'b0);
    end

    // rst mid-read with cs held low, then a fresh command in the same cs-low window
    rdata[0] = $urandom;
    rdata[1] = $urandom;
    run_frame(8'h72, 24'h000200, 45);
    idle_edge(1'b0, 1'b1);
    wdata[0] = 32'h0BADCAFE;
    run_frame(8'h77, 24'h000300, 64);
    check("post_rst_wr_strobes", 0, 32'(wr_cnt), 32'd1);
    check("post_rst_wr_data", 0, wr_data_out, 32'h0BADCAFE);
    idle_edge(1'b1, 1'b1);

    for (int r = 0; r < 10; r++) begin
      logic [7:0]  c;
      logic [23:0] a;
      int sel, nw;
      sel = $urandom_range(0, 2);
      if (sel == 0) c = 8'h77;
      else if (sel == 1) c = 8'h72;
      else begin
        c = 8'($urandom);
        if (c == 8'h77 || c == 8'h72) c = 8'h00;
      end
      if ($urandom_range(0, 1) == 1) a = 24'hFFFFFF - 24'($urandom_range(0, 2));
      else a = 24'($urandom);
      nw = $urandom_range(1, 3);
      for (int j = 0; j < 8; j++) begin
        wdata[j] = $urandom;
        rdata[j] = $urandom;
      end
      run_frame(c, a, 32 + nw*32 + $urandom_range(0, 31));
      idle_edge(1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
